// File: rtl/rhythm_pkg.sv
// Shared constants and lane state type for the rhythm-game judgement stage.
package rhythm_pkg;

    localparam int unsigned NUM_LANES      = 4;
    localparam int unsigned ZONE_HIT_ROWS  = 2;
    localparam int unsigned ZONE_NEAR_ROWS = 2;
    localparam int unsigned ZONE_ROWS      = ZONE_HIT_ROWS + ZONE_NEAR_ROWS;
    localparam int unsigned PTS_HIT        = 2;
    localparam int unsigned PTS_NEAR       = 1;

    typedef enum logic [1:0] {
        EMPTY,
        PENDING,
        DONE
    } lane_state_t;

endpackage

// File: rtl/hit_judge_if.sv
// Note field, buttons and judgement results exchanged with the hit_judge stage.
interface hit_judge_if;
    import rhythm_pkg::*;

    logic [15:0][15:0]      RedPixels;
    logic [NUM_LANES-1:0]   KEY;
    logic [NUM_LANES-1:0]   hit;
    logic [NUM_LANES-1:0]   near;
    logic [NUM_LANES-1:0]   miss;
    logic [9:0]             score;
    logic [7:0]             combo;

    modport master (
        output RedPixels, KEY,
        input  hit, near, miss, score, combo
    );

    modport slave (
        input  RedPixels, KEY,
        output hit, near, miss, score, combo
    );

endinterface

// File: rtl/lane_judge.sv
// Per-lane judgement FSM: grades the first press on each note, flags unplayed notes.
module lane_judge
    import rhythm_pkg::*;
#(
    parameter bit GHOST_MISS = 1'b1
) (
    input  logic clk,
    input  logic RST,
    input  logic press,
    input  logic hit_zone,
    input  logic near_zone,
    output logic hit,
    output logic near,
    output logic miss,
    output logic hit_d,
    output logic near_d,
    output logic miss_d
);

    lane_state_t state_q, state_d;
    logic        occupied;

    assign occupied = hit_zone | near_zone;

    always_comb begin
        state_d = state_q;
        hit_d   = 1'b0;
        near_d  = 1'b0;
        miss_d  = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (occupied) begin
                    // A press landing with the note's arrival is graded at once.
                    if (press) begin
                        hit_d   = hit_zone;
                        near_d  = ~hit_zone;
                        state_d = DONE;
                    end else begin
                        state_d = PENDING;
                    end
                end else if (press) begin
                    miss_d = GHOST_MISS;
                end
            end
            PENDING: begin
                if (!occupied) begin
                    miss_d  = 1'b1;
                    state_d = EMPTY;
                end else if (press) begin
                    hit_d   = hit_zone;
                    near_d  = ~hit_zone;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!occupied) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q <= EMPTY;
            hit     <= 1'b0;
            near    <= 1'b0;
            miss    <= 1'b0;
        end else begin
            state_q <= state_d;
            hit     <= hit_d;
            near    <= near_d;
            miss    <= miss_d;
        end
    end

endmodule

// File: rtl/hit_judge.sv
// Judgement stage: key synchronisers, lane zone mapping, per-lane FSMs and
// the saturating score/combo counters.
module hit_judge
    import rhythm_pkg::*;
#(
    parameter int unsigned LANE_COL0  = 12,
    parameter int unsigned SCORE_MAX  = 999,
    parameter bit          GHOST_MISS = 1'b1
) (
    input  logic  clk,
    input  logic  RST,
    hit_judge_if.slave bus
);

    logic [NUM_LANES-1:0] key_meta, key_sync, key_prev, press;
    logic [NUM_LANES-1:0] hit_zone, near_zone;
    logic [NUM_LANES-1:0] hit_q, near_q, miss_q;
    logic [NUM_LANES-1:0] hit_d, near_d, miss_d;
    logic [9:0]           score_q, score_d;
    logic [7:0]           combo_q, combo_d;
    logic [2:0]           n_hit, n_near, n_good;
    logic [3:0]           delta;
    logic [10:0]          score_sum;
    logic [8:0]           combo_sum;
    logic                 unused_pixels;

    // Only the bottom rows of the lane columns take part in judgement.
    assign unused_pixels = ^bus.RedPixels;

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            key_meta <= '0;
            key_sync <= '0;
            key_prev <= '0;
        end else begin
            key_meta <= ~bus.KEY;
            key_sync <= key_meta;
            key_prev <= key_sync;
        end
    end

    assign press = key_sync & ~key_prev;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        localparam int unsigned Col = LANE_COL0 + g;
        logic [ZONE_ROWS-1:0] col_bits;

        for (genvar r = 0; r < ZONE_ROWS; r++) begin : g_row
            assign col_bits[r] = bus.RedPixels[r][Col];
        end

        assign hit_zone[g]  = |col_bits[ZONE_HIT_ROWS-1:0];
        assign near_zone[g] = |col_bits[ZONE_ROWS-1:ZONE_HIT_ROWS];

        lane_judge #(
            .GHOST_MISS(GHOST_MISS)
        ) u_lane (
            .clk      (clk),
            .RST      (RST),
            .press    (press[g]),
            .hit_zone (hit_zone[g]),
            .near_zone(near_zone[g]),
            .hit      (hit_q[g]),
            .near     (near_q[g]),
            .miss     (miss_q[g]),
            .hit_d    (hit_d[g]),
            .near_d   (near_d[g]),
            .miss_d   (miss_d[g])
        );
    end

    // Counters use the lanes' next-state pulses so they move on the same edge.
    always_comb begin
        n_hit     = 3'($countones(hit_d));
        n_near    = 3'($countones(near_d));
        n_good    = 3'($countones(hit_d | near_d));
        delta     = 4'(PTS_HIT * n_hit + PTS_NEAR * n_near);
        score_sum = {1'b0, score_q} + 11'(delta);
        score_d   = (score_sum > 11'(SCORE_MAX)) ? 10'(SCORE_MAX) : score_sum[9:0];
        combo_sum = {1'b0, combo_q} + 9'(n_good);
        if (|miss_d) begin
            combo_d = '0;
        end else begin
            combo_d = combo_sum[8] ? 8'hff : combo_sum[7:0];
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            score_q <= '0;
            combo_q <= '0;
        end else begin
            score_q <= score_d;
            combo_q <= combo_d;
        end
    end

    assign bus.hit   = hit_q;
    assign bus.near  = near_q;
    assign bus.miss  = miss_q;
    assign bus.score = score_q;
    assign bus.combo = combo_q;

endmodule

// File: doc/hit_judge.md
# hit_judge

Judgement stage directly downstream of the falling-note field in the rhythm game. Each cycle it samples the 16x16 red note field and the four lane push-buttons. It grades every press as hit, near or miss, and also flags notes that scroll off the field unplayed. It keeps a running score and combo for the seven-segment and status display logic.

## Interface
Parameters:
- LANE_COL0, 12: matrix column of lane 0; lanes 0..3 map to columns LANE_COL0..LANE_COL0+3
- SCORE_MAX, 999: saturation value of score
- GHOST_MISS, 1: 1 = a press with an empty zone counts as a miss; 0 = ignored

Ports:
- clk  input  1  system clock
- RST  input  1  reset, asynchronous, active-low (asserted at 0)
- RedPixels  input  [15:0][15:0]  note field, [row][col]; row 0 is the bottom (arrival) row; registered upstream
- KEY  input  4  lane buttons, active-low, asynchronous to clk
- hit  output  4  one-cycle pulse per lane: graded hit
- near  output  4  one-cycle pulse per lane: graded near
- miss  output  4  one-cycle pulse per lane: miss (late, unplayed or ghost)
- score  output  10  running score, binary, saturating
- combo  output  8  consecutive non-miss judgements, saturating at 255

## Operation
- Key path, per lane: 2-flop synchronizer on ~KEY, then a previous-value flop. press = sync & ~prev, one cycle per physical press.
- Zones, per lane column c:
  - hit_zone = RedPixels[0][c] | RedPixels[1][c]
  - near_zone = RedPixels[2][c] | RedPixels[3][c]
  - occupied = hit_zone | near_zone
- Lane FSM (lane_state_t), one per lane:
  - EMPTY: on occupied, go to PENDING. On press with !occupied, pulse miss if GHOST_MISS and stay in EMPTY.
  - PENDING, on press: pulse hit if hit_zone, otherwise near (near_zone only). Go to DONE.
  - PENDING, on !occupied with no press: pulse miss (note scrolled out unplayed). Go to EMPTY.
  - DONE: ignore presses, with no pulse. On !occupied, go to EMPTY.
- Simultaneous press and zone emptying in the same cycle in PENDING: the zone is already empty, so grade as miss. Go to EMPTY.
- Press on EMPTY while occupied rises in the same cycle: treat as PENDING+press. Grade it and go to DONE.
- Arithmetic, summed over all lanes in one cycle:
  - delta = 2·popcount(hit) + popcount(near)
  - score_next = min(score + delta, SCORE_MAX), computed 11 bits wide
  - combo: if any miss pulses this cycle, combo = 0. Otherwise combo = min(combo + popcount(hit|near), 255).
  - Miss takes priority over hit/near in the same cycle.

## Timing
- Reset (RST=0, async): all FSMs EMPTY; synchronizer and prev flops 0; hit/near/miss/score/combo = 0.
- Reset release is synchronous in effect; the first judgement is possible on the third edge after release.
- Latency: KEY first sampled low at edge k. The press pulse is valid between edges k+1 and k+2. hit/near/miss are registered at edge k+2 and high for exactly one cycle.
- score and combo update at the same edge as the pulses.
- RedPixels is sampled combinationally at the judging edge, with no extra delay.
- A held button produces a single press. Re-pressing needs KEY high for at least 2 cycles.
- Reset mid-operation: pulses drop immediately, and any pending notes are forgotten without a miss.

## Structure
- rhythm_pkg holds:
  - NUM_LANES = 4
  - ZONE_HIT_ROWS and ZONE_NEAR_ROWS constants
  - PTS_HIT = 2, PTS_NEAR = 1
  - typedef enum logic [1:0] lane_state_t {EMPTY, PENDING, DONE}
- Sub-module lane_judge, instantiated once per lane:
  - inputs: press, hit_zone, near_zone
  - FSM plus registered hit/near/miss outputs
- The top level holds the synchronizers, the popcount/saturating score and combo logic, and the column mapping.

## Test plan
- Reset hold then release with KEY=4'hF and an empty field → all outputs 0 for 20 cycles.
- Lane 0: pixel at [1][12]; KEY[0] low at edge k → hit[0] high for one cycle at edge k+2; score=2, combo=1; no further pulse while held.
- Lane 2: pixel at [3][14], then press → near[2]. Then scroll [3]→[1]→off while the key is still held → no pulse; score+1, FSM passes DONE→EMPTY.
- Lane 3: note enters rows 2-3 and scrolls off unplayed → miss[3] on the edge the zone empties; combo resets to 0; score unchanged.
- Ghost press on lane 1 with an empty zone → miss[1] when GHOST_MISS=1; no pulse when GHOST_MISS=0.
- Score at 998; all four lanes press in the same cycle with pixels in row 0 → hit=4'hF, score saturates at 999, combo += 4. Then assert RST mid-pulse → all outputs 0 asynchronously.
